mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_sequencer_if.sv | 41 ++++
 rtl/mux_scan_sequencer.sv | 92 +++++++++
 tb/tb_mux_scan_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if
//
// Purpose: bundles the handshake and mux-facing signals of mux_scan_sequencer.
//
// Signals:
//   start  request a scan (driven by the host)
//   y_in   multiplexer output, a combinational function of sel (driven by the mux side)
//   sel    3-bit select driven to the multiplexer
//   busy   high while a scan is in progress
//   done   one-cycle pulse when a new word is valid on data
//   data   last completed 8-bit word
//
// Modports:
//   master  host / mux side: drives start and y_in, observes the rest
//   slave   the sequencer itself
interface mux_scan_sequencer_if;
    logic       start;
    logic       y_in;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic [7:0] data;

    modport master (
        output start,
        output y_in,
        input  sel,
        input  busy,
        input  done,
        input  data
    );

    modport slave (
        input  start,
        input  y_in,
        output sel,
        output busy,
        output done,
        output data
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//
// Purpose: steps an 8:1 multiplexer select through channels 0..7, waits SETTLE cycles after
// each select change, samples the mux output, and assembles the eight samples into a
// parallel word reported with a start/busy/done handshake.
//
// Parameters:
//   SETTLE  wait cycles after each select change before sampling (0..15)
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux_scan_sequencer_if.slave: start, y_in in; sel, busy, done, data out
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input logic                 clk,
    input logic                 rst,
    mux_scan_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWait, StSample} state_e;

    // Counter reloads to SETTLE-1 so that WAIT lasts exactly SETTLE cycles.
    localparam logic [3:0] CntReload  = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    // SETTLE=0 skips WAIT entirely and samples on the very next edge.
    localparam state_e     StAfterSel = (SETTLE == 0) ? StSample : StWait;

    state_e     state_q;
    logic [2:0] sel_q;
    logic [3:0] cnt_q;
    logic [6:0] shadow_q;
    logic [7:0] data_q;
    logic       busy_q;
    logic       done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= 3'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 7'd0;
            data_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Also reached in the done cycle, so a held start chains scans with no gap.
                    if (bus.start) begin
                        sel_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        cnt_q   <= CntReload;
                        state_q <= StAfterSel;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StSample: begin
                    if (sel_q != 3'd7) begin
                        shadow_q[sel_q] <= bus.y_in;
                        sel_q           <= sel_q + 3'd1;
                        cnt_q           <= CntReload;
                        state_q         <= StAfterSel;
                    end else begin
                        // Last channel goes straight into data; shadow only holds 0..6.
                        data_q  <= {bus.y_in, shadow_q};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        sel_q   <= 3'd0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.data = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
//
// Self-checking bench for mux_scan_sequencer. Two instances (SETTLE=1 and SETTLE=0) each sit
// behind a modelled 8:1 mux (y_in = pattern[sel]). Walking-one scans are table driven; the
// multi-cycle corner cases (sel trace, ignored start, back-to-back, mid-scan reset) are
// hand-written sequences.
module tb_mux_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_scan_sequencer_if bus1 ();
    mux_scan_sequencer_if bus0 ();

    logic [7:0] pat1 = 8'h00;
    logic [7:0] pat0 = 8'h00;

    // Mux models.
    assign bus1.y_in = pat1[bus1.sel];
    assign bus0.y_in = pat0[bus0.sel];

    mux_scan_sequencer #(.SETTLE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mux_scan_sequencer #(.SETTLE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [7:0] pat;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic g_busy(input bit w);
        return w ? bus1.busy : bus0.busy;
    endfunction

    function automatic logic g_done(input bit w);
        return w ? bus1.done : bus0.done;
    endfunction

    function automatic logic [2:0] g_sel(input bit w);
        return w ? bus1.sel : bus0.sel;
    endfunction

    function automatic logic [7:0] g_data(input bit w);
        return w ? bus1.data : bus0.data;
    endfunction

    task automatic set_start(input bit w, input logic v);
        if (w) bus1.start = v;
        else   bus0.start = v;
    endtask

    // Runs one scan on instance w (1: SETTLE=1, 0: SETTLE=0). Entered and left #1 after an edge.
    // Returns #1 after the completion edge (done high), with start left high if !release_start.
    task automatic scan(input bit w, input logic [7:0] pat, input bit release_start,
                        input int pulse_at, input logic [7:0] exp_data,
                        input logic [7:0] exp_hold, input string name);
        int settle_cyc;
        int exp_done;
        int done_at;
        int busy_cnt;
        bit hold_ok;
        bit sel_ok;
        bit both_ok;
        settle_cyc = w ? 2 : 1;
        exp_done   = 8 * settle_cyc;
        done_at    = -1;
        busy_cnt   = 0;
        hold_ok    = 1'b1;
        sel_ok     = 1'b1;
        both_ok    = 1'b1;
        if (w) pat1 = pat;
        else   pat0 = pat;
        set_start(w, 1'b1);
        @(posedge clk);  // E0
        #1;
        if (release_start) set_start(w, 1'b0);
        for (int n = 0; n <= exp_done + 8; n++) begin
            if (pulse_at >= 0 && n == pulse_at)     set_start(w, 1'b1);
            if (pulse_at >= 0 && n == pulse_at + 1) set_start(w, 1'b0);
            if (g_busy(w) && g_done(w)) both_ok = 1'b0;
            if (g_done(w)) begin
                done_at = n;
                break;
            end
            if (g_busy(w)) busy_cnt++;
            if (g_data(w) !== exp_hold) hold_ok = 1'b0;
            if (g_sel(w) !== 3'(n / settle_cyc)) sel_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check({name, " done_latency"}, done_at, exp_done);
        check({name, " busy_cycles"}, busy_cnt, exp_done);
        check({name, " data"}, g_data(w), exp_data);
        check({name, " data_hold"}, hold_ok, 1'b1);
        check({name, " sel_trace"}, sel_ok, 1'b1);
        check({name, " sel_at_done"}, g_sel(w), 3'd0);
        check({name, " busy_done_excl"}, both_ok, 1'b1);
    endtask

    initial begin
        logic [7:0] prev;
        bit         quiet;

        vecs[0] = '{"walk0", 8'b0000_0001, 8'h01};
        vecs[1] = '{"walk1", 8'b0000_0010, 8'h02};
        vecs[2] = '{"walk2", 8'b0000_0100, 8'h04};
        vecs[3] = '{"walk3", 8'b0000_1000, 8'h08};
        vecs[4] = '{"walk4", 8'b0001_0000, 8'h10};
        vecs[5] = '{"walk5", 8'b0010_0000, 8'h20};
        vecs[6] = '{"walk6", 8'b0100_0000, 8'h40};
        vecs[7] = '{"walk7", 8'b1000_0000, 8'h80};

        bus1.start = 1'b0;
        bus0.start = 1'b0;

        // Asynchronous reset with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("rst_sel", bus1.sel, 3'd0);
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_done", bus1.done, 1'b0);
        check("rst_data", bus1.data, 8'h00);
        check("rst_data_s0", bus0.data, 8'h00);
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_sel", bus1.sel, 3'd0);
        check("idle_busy", bus1.busy, 1'b0);
        check("idle_done", bus1.done, 1'b0);
        check("idle_data", bus1.data, 8'h00);

        // Walking one, SETTLE=1.
        prev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            scan(1'b1, vecs[i].pat, 1'b1, -1, vecs[i].exp_data, prev, vecs[i].name);
            prev = vecs[i].exp_data;
            @(posedge clk);
            #1;
            check({vecs[i].name, " done_pulse_end"}, bus1.done, 1'b0);
        end

        // A5 with sel trace; start re-pulsed at cycle 5 must be ignored.
        scan(1'b1, 8'hA5, 1'b1, 5, 8'hA5, 8'h80, "a5");
        quiet = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            if (bus1.busy || bus1.done) quiet = 1'b0;
        end
        check("a5_single_done", quiet, 1'b1);

        // Back-to-back: start held high across done, pattern swapped at done.
        scan(1'b1, 8'hA5, 1'b0, -1, 8'hA5, 8'hA5, "b2b_first");
        scan(1'b1, 8'h3C, 1'b1, -1, 8'h3C, 8'hA5, "b2b_second");
        @(posedge clk);
        #1;

        // SETTLE=0 instance.
        scan(1'b0, 8'h81, 1'b1, -1, 8'h81, 8'h00, "settle0");
        @(posedge clk);
        #1;

        // Mid-scan reset at cycle 9.
        pat1       = 8'h5A;
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", bus1.busy, 1'b0);
        check("midrst_sel", bus1.sel, 3'd0);
        check("midrst_done", bus1.done, 1'b0);
        check("midrst_data", bus1.data, 8'h00);
        check("midrst_data_s0", bus0.data, 8'h00);
        @(posedge clk);
        #3;
        rst = 1'b0;
        quiet = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bus1.busy || bus1.done || bus1.data !== 8'h00) quiet = 1'b0;
        end
        check("midrst_no_done", quiet, 1'b1);
        scan(1'b1, 8'hFF, 1'b1, -1, 8'hFF, 8'h00, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
